// File: rtl/uart_frame_parser_pkg.sv
// Shared types for the UART command-frame parser: FSM states, error codes, default header.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_PLD  = 3'd3,
        S_CSUM = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] DEF_HEADER = 8'hA5;

    // Address/counter width able to hold values 0..depth-1 (never below 1 bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload store: P_DEPTH x 8 simple dual-port RAM, one write port, one read port.
// Latency: read data appears one clock after rd_en/rd_addr; write lands at the clock edge.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module uart_frame_parser_buf #(
    parameter int P_DEPTH = 16,
    parameter int P_AW    = 4
) (
    input  logic            w_user_clk,
    input  logic            wr_en,
    input  logic [P_AW-1:0] wr_addr,
    input  logic [7:0]      wr_dat,
    input  logic            rd_en,
    input  logic [P_AW-1:0] rd_addr,
    output logic [7:0]      rd_dat
);

    logic [7:0] mem_q [P_DEPTH];
    logic [7:0] rd_dat_q;
    logic [7:0] rd_dat_d;

    // Next read-data value: only refreshed on an explicit read so a stalled consumer sees stable data.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    // Memory array and registered read port.
    always_ff @(posedge w_user_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 0xA5|CMD|LEN|payload|CSUM frames from a UART byte strobe and streams verified payloads.
// Latency: CSUM byte at N -> o_frm_ok at N+1, first payload beat at N+2; then 1 beat/clk.
// Backpressure: i_pld_ready stalls the payload stream; bytes arriving while streaming are dropped (o_overrun).
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int         P_MAX_LEN      = 16,
    parameter int         P_TIMEOUT_CLKS = 50000,
    parameter logic [7:0] P_HEADER       = DEF_HEADER
) (
    input  logic       w_user_clk,
    input  logic       w_user_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_frm_cmd,
    output logic [7:0] o_frm_len,
    output logic       o_frm_ok,
    output logic       o_frm_err,
    output logic [1:0] o_err_code,
    output logic [7:0] o_pld_data,
    output logic       o_pld_valid,
    output logic       o_pld_last,
    input  logic       i_pld_ready,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int              AW        = addr_w(P_MAX_LEN);
    localparam int              TW        = addr_w(P_TIMEOUT_CLKS);
    localparam logic [TW-1:0]   TMO_MAX   = TW'(P_TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(P_MAX_LEN);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    wr_idx_q, wr_idx_d;
    logic [7:0]    rd_idx_q, rd_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frm_ok_q, frm_ok_d;
    logic          frm_err_q, frm_err_d;
    err_code_t     err_code_q, err_code_d;
    logic [7:0]    frm_cmd_q, frm_cmd_d;
    logic [7:0]    frm_len_q, frm_len_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    // RAM output stage: rd_dat holds a fetched beat not yet moved to the output register.
    logic          ram_vld_q, ram_vld_d;
    logic          ram_last_q, ram_last_d;
    // Output register presented to the consumer.
    logic          out_vld_q, out_vld_d;
    logic [7:0]    out_dat_q, out_dat_d;
    logic          out_last_q, out_last_d;

    logic          in_frame;
    logic          tmo_hit;
    logic          move;
    logic          buf_we;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_dat;

    uart_frame_parser_buf #(
        .P_DEPTH (P_MAX_LEN),
        .P_AW    (AW)
    ) u_buf (
        .w_user_clk (w_user_clk),
        .wr_en      (buf_we),
        .wr_addr    (wr_idx_q[AW-1:0]),
        .wr_dat     (i_rx_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_dat     (rd_dat)
    );

    assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_PLD) || (state_q == S_CSUM);
    assign tmo_hit  = in_frame && !i_rx_valid && (tmo_q == TMO_MAX);
    assign move     = ram_vld_q && (!out_vld_q || i_pld_ready);

    // Next-state logic: frame assembly, checksum, timeout, and the prefetching output pipeline.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        tmo_d      = '0;
        frm_ok_d   = 1'b0;
        frm_err_d  = 1'b0;
        err_code_d = err_code_q;
        frm_cmd_d  = frm_cmd_q;
        frm_len_d  = frm_len_q;
        overrun_d  = 1'b0;
        ram_vld_d  = ram_vld_q;
        ram_last_d = ram_last_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        buf_we     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;

        if (in_frame && !i_rx_valid) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == P_HEADER)) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (i_rx_valid) begin
                    cmd_d   = i_rx_data;
                    csum_d  = i_rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_valid) begin
                    len_d    = i_rx_data;
                    csum_d   = csum_q + i_rx_data;
                    wr_idx_d = '0;
                    if (i_rx_data > MAX_LEN_B) begin
                        frm_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_IDLE;
                    end else if (i_rx_data == 8'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_PLD;
                    end
                end
            end
            S_PLD: begin
                if (i_rx_valid) begin
                    buf_we   = 1'b1;
                    csum_d   = csum_q + i_rx_data;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if ((wr_idx_q + 8'd1) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (i_rx_valid) begin
                    if (i_rx_data != csum_q) begin
                        frm_err_d  = 1'b1;
                        err_code_d = ERR_CSUM;
                        state_d    = S_IDLE;
                    end else begin
                        frm_ok_d  = 1'b1;
                        frm_cmd_d = cmd_q;
                        frm_len_d = len_q;
                        if (len_q == 8'd0) begin
                            state_d = S_IDLE;
                        end else begin
                            // Issue the first read now so the first beat is presented one clock after o_frm_ok.
                            state_d    = S_OUT;
                            rd_en      = 1'b1;
                            rd_idx_d   = 8'd1;
                            ram_vld_d  = 1'b1;
                            ram_last_d = (len_q == 8'd1);
                            out_vld_d  = 1'b0;
                        end
                    end
                end
            end
            S_OUT: begin
                if (i_rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (out_vld_q && i_pld_ready) begin
                    out_vld_d = 1'b0;
                end
                if (move) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = rd_dat;
                    out_last_d = ram_last_q;
                    ram_vld_d  = 1'b0;
                end
                // Prefetch whenever the RAM stage will be free next clock.
                if ((rd_idx_q != len_q) && (!ram_vld_q || move)) begin
                    rd_en      = 1'b1;
                    rd_addr    = rd_idx_q[AW-1:0];
                    rd_idx_d   = rd_idx_q + 8'd1;
                    ram_vld_d  = 1'b1;
                    ram_last_d = ((rd_idx_q + 8'd1) == len_q);
                end
                if (out_vld_q && i_pld_ready && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle gap inside a frame expired: abandon the frame.
        if (tmo_hit) begin
            frm_err_d  = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = S_IDLE;
            tmo_d      = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // All parser state and registered outputs; reset discards any frame in progress.
    always_ff @(posedge w_user_clk or posedge w_user_rst) begin
        if (w_user_rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            tmo_q      <= '0;
            frm_ok_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            frm_cmd_q  <= '0;
            frm_len_q  <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            ram_vld_q  <= 1'b0;
            ram_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            tmo_q      <= tmo_d;
            frm_ok_q   <= frm_ok_d;
            frm_err_q  <= frm_err_d;
            err_code_q <= err_code_d;
            frm_cmd_q  <= frm_cmd_d;
            frm_len_q  <= frm_len_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            ram_vld_q  <= ram_vld_d;
            ram_last_q <= ram_last_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
        end
    end

    assign o_frm_cmd   = frm_cmd_q;
    assign o_frm_len   = frm_len_q;
    assign o_frm_ok    = frm_ok_q;
    assign o_frm_err   = frm_err_q;
    assign o_err_code  = err_code_q;
    assign o_pld_data  = out_dat_q;
    assign o_pld_valid = out_vld_q;
    assign o_pld_last  = out_last_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a scoreboard of expected frame events and payload beats.
// Latency: checks o_frm_ok at N+1, first beat at N+2, timeout expiry at exactly P_TIMEOUT_CLKS clocks.
// Backpressure: random i_pld_ready phase checks beat stability while stalled.
module tb_uart_frame_parser;

    localparam int TMO = 100;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        logic [7:0] cmd;
        logic [7:0] len;
    } fev_t;

    typedef logic [7:0] bq_t[$];

    logic       w_user_clk = 1'b0;
    logic       w_user_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       i_pld_ready;
    logic [7:0] o_frm_cmd;
    logic [7:0] o_frm_len;
    logic       o_frm_ok;
    logic       o_frm_err;
    logic [1:0] o_err_code;
    logic [7:0] o_pld_data;
    logic       o_pld_valid;
    logic       o_pld_last;
    logic       o_overrun;
    logic       o_busy;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         beats_seen = 0;
    bit         rdy_rand = 1'b0;
    bit         stall_q  = 1'b0;
    logic [7:0] held_dat;
    logic       held_last;

    logic [8:0] exp_beats[$];
    fev_t       exp_frm[$];

    uart_frame_parser #(
        .P_MAX_LEN      (16),
        .P_TIMEOUT_CLKS (TMO),
        .P_HEADER       (8'hA5)
    ) dut (
        .w_user_clk  (w_user_clk),
        .w_user_rst  (w_user_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_frm_cmd   (o_frm_cmd),
        .o_frm_len   (o_frm_len),
        .o_frm_ok    (o_frm_ok),
        .o_frm_err   (o_frm_err),
        .o_err_code  (o_err_code),
        .o_pld_data  (o_pld_data),
        .o_pld_valid (o_pld_valid),
        .o_pld_last  (o_pld_last),
        .i_pld_ready (i_pld_ready),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 w_user_clk = ~w_user_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_user_clk);
        #2;
        if (rdy_rand) i_pld_ready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic push_ok(input logic [7:0] cmd, input logic [7:0] len);
        fev_t ev;
        ev.is_err = 1'b0; ev.code = 2'd0; ev.cmd = cmd; ev.len = len;
        exp_frm.push_back(ev);
    endtask

    task automatic push_err(input logic [1:0] code);
        fev_t ev;
        ev.is_err = 1'b1; ev.code = code; ev.cmd = 8'h00; ev.len = 8'h00;
        exp_frm.push_back(ev);
    endtask

    // Builds a frame from cmd + payload, computing the checksum and expectations from the frame format.
    task automatic send_frame(input logic [7:0] cmd, input bq_t p);
        logic [7:0] cs;
        logic [7:0] len;
        len = 8'(p.size());
        cs  = cmd + len;
        foreach (p[i]) cs = cs + p[i];
        push_ok(cmd, len);
        foreach (p[i]) exp_beats.push_back({(i == p.size() - 1), p[i]});
        send(8'hA5); send(cmd); send(len);
        foreach (p[i]) send(p[i]);
        send(cs);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((o_busy || exp_beats.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, (n < 300), 1);
    endtask

    function automatic logic [31:0] all_outs();
        return {o_frm_cmd, o_frm_len, o_frm_ok, o_frm_err, o_err_code,
                o_pld_data, o_pld_valid, o_pld_last, o_overrun, o_busy};
    endfunction

    // Scoreboard monitor: samples mid-cycle, retires beats and frame events as the DUT produces them.
    always @(negedge w_user_clk) begin
        if (w_user_rst !== 1'b0) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_valid", o_pld_valid, 1);
                chk("stall_data", o_pld_data, held_dat);
                chk("stall_last", o_pld_last, held_last);
            end
            if (o_pld_valid && i_pld_ready) begin
                chk("beat_expected", (exp_beats.size() > 0), 1);
                if (exp_beats.size() > 0) begin
                    logic [8:0] e;
                    e = exp_beats.pop_front();
                    chk("beat_data", o_pld_data, e[7:0]);
                    chk("beat_last", o_pld_last, e[8]);
                end
                beats_seen++;
            end
            stall_q   = o_pld_valid && !i_pld_ready;
            held_dat  = o_pld_data;
            held_last = o_pld_last;
            if (o_frm_ok || o_frm_err) begin
                chk("frame_event_expected", (exp_frm.size() > 0), 1);
                if (exp_frm.size() > 0) begin
                    fev_t ev;
                    ev = exp_frm.pop_front();
                    chk("frame_event_kind", o_frm_err, ev.is_err);
                    chk("ok_err_exclusive", (o_frm_ok && o_frm_err), 0);
                    if (ev.is_err) begin
                        chk("err_code", o_err_code, ev.code);
                    end else begin
                        chk("frm_cmd", o_frm_cmd, ev.cmd);
                        chk("frm_len", o_frm_len, ev.len);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t pl;
        int  n;
        int  b0;

        w_user_rst  = 1'b1;
        i_rx_data   = 8'h00;
        i_rx_valid  = 1'b0;
        i_pld_ready = 1'b1;
        #1;
        chk("reset_outputs", all_outs(), 0);
        tick(); tick();
        w_user_rst = 1'b0;
        tick();
        chk("idle_after_reset", all_outs(), 0);

        // Case 1: good 3-byte frame, ready held high.
        push_ok(8'h10, 8'h03);
        exp_beats.push_back({1'b0, 8'h11});
        exp_beats.push_back({1'b0, 8'h22});
        exp_beats.push_back({1'b1, 8'h33});
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("busy_in_frame", o_busy, 1);
        send(8'h79);
        chk("c1_ok_n1", o_frm_ok, 1);
        chk("c1_cmd_n1", o_frm_cmd, 8'h10);
        chk("c1_len_n1", o_frm_len, 8'h03);
        chk("c1_no_beat_n1", o_pld_valid, 0);
        tick();
        chk("c1_beat0_vld", o_pld_valid, 1);
        chk("c1_beat0_dat", o_pld_data, 8'h11);
        tick();
        chk("c1_beat1_vld", o_pld_valid, 1);
        chk("c1_beat1_dat", o_pld_data, 8'h22);
        tick();
        chk("c1_beat2_vld", o_pld_valid, 1);
        chk("c1_beat2_last", o_pld_last, 1);
        tick();
        chk("c1_done_vld", o_pld_valid, 0);
        chk("c1_done_busy", o_busy, 0);
        chk("c1_no_err", o_frm_err, 0);

        // Case 2: bad checksum, then a good frame carrying 0xA5 as payload.
        push_err(2'd1);
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h78);
        chk("c2_err", o_frm_err, 1);
        chk("c2_code", o_err_code, 2'd1);
        tick(); tick(); tick();
        chk("c2_no_beats", o_pld_valid, 0);
        chk("c2_idle", o_busy, 0);
        pl.delete();
        pl.push_back(8'h01); pl.push_back(8'hA5); pl.push_back(8'h02);
        send_frame(8'h07, pl);
        wait_idle("c2_recover_drain");

        // Case 3: LEN above the limit, trailing bytes ignored; LEN at the limit accepted.
        push_err(2'd2);
        send(8'hA5); send(8'h01); send(8'h20);
        chk("c3_err", o_frm_err, 1);
        chk("c3_code", o_err_code, 2'd2);
        send(8'h11); send(8'h22); send(8'h00);
        tick();
        chk("c3_ignored_busy", o_busy, 0);
        chk("c3_ignored_ok", o_frm_ok, 0);
        push_err(2'd2);
        send(8'hA5); send(8'h01); send(8'h11);
        chk("c3_len17_code", o_err_code, 2'd2);
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'(i * 17 + 3));
        send_frame(8'h20, pl);
        wait_idle("c3_len16_drain");

        // Case 4: inter-byte timeout; the previous error code is held until then.
        chk("c4_code_held", o_err_code, 2'd2);
        push_err(2'd3);
        send(8'hA5); send(8'h01); send(8'h02); send(8'hAA);
        chk("c4_busy", o_busy, 1);
        n = 0;
        while (n < 3 * TMO) begin
            tick();
            n++;
            if (o_frm_err) break;
        end
        chk("c4_timeout_clks", n, TMO);
        chk("c4_code", o_err_code, 2'd3);
        chk("c4_busy_fall", o_busy, 0);

        // Case 5: random backpressure plus a byte dropped while streaming.
        b0 = beats_seen;
        rdy_rand = 1'b1;
        push_ok(8'h10, 8'h03);
        exp_beats.push_back({1'b0, 8'h11});
        exp_beats.push_back({1'b0, 8'h22});
        exp_beats.push_back({1'b1, 8'h33});
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h79);
        tick(); tick();
        send(8'h5A);
        chk("c5_overrun", o_overrun, 1);
        tick();
        chk("c5_overrun_pulse", o_overrun, 0);
        wait_idle("c5_drain");
        chk("c5_beat_count", beats_seen - b0, 3);
        rdy_rand = 1'b0;
        i_pld_ready = 1'b1;
        tick();

        // Case 6: reset after the first beat, then an empty frame.
        b0 = beats_seen;
        push_ok(8'h10, 8'h03);
        exp_beats.push_back({1'b0, 8'h11});
        exp_beats.push_back({1'b0, 8'h22});
        exp_beats.push_back({1'b1, 8'h33});
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h79);
        tick(); tick();
        w_user_rst = 1'b1;
        #1;
        chk("c6_reset_outputs", all_outs(), 0);
        chk("c6_one_beat", beats_seen - b0, 1);
        exp_beats.delete();
        tick(); tick();
        w_user_rst = 1'b0;
        tick(); tick(); tick();
        chk("c6_no_more_beats", o_pld_valid, 0);
        push_ok(8'h00, 8'h00);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        chk("c6_empty_ok", o_frm_ok, 1);
        chk("c6_empty_len", o_frm_len, 8'h00);
        tick(); tick(); tick();
        chk("c6_empty_no_beats", o_pld_valid, 0);
        chk("c6_empty_idle", o_busy, 0);
        chk("c6_beats_after_reset", beats_seen - b0, 1);

        chk("beat_queue_empty", exp_beats.size(), 0);
        chk("frame_queue_empty", exp_frm.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
